data_mem_responder: RTL

// - Memory-side responder for the CPU's load/store request port. It sits between the

---
 rtl/data_mem_responder.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Load/store memory responder: in-order request FIFO, programmable access latency,
// byte/half/word access to a word-addressed RAM, one tagged response per request.
module data_mem_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_WORDS  = 1024,
    parameter int REQ_DEPTH  = 4,
    parameter int LATENCY    = 2,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_is_store,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_wdata,
    input  logic [TAG_WIDTH-1:0]  req_tag,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_is_store,
    output logic [31:0]           resp_rdata,
    output logic [TAG_WIDTH-1:0]  resp_tag,
    output logic                  resp_error
);
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int PTR_W = $clog2(REQ_DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef struct packed {
        logic                  is_store;
        logic [ADDR_WIDTH-1:0] addr;
        logic [1:0]            size;
        logic                  is_unsigned;
        logic [31:0]           wdata;
        logic [TAG_WIDTH-1:0]  tag;
    } req_t;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    req_t        fifo_mem [REQ_DEPTH];
    logic [31:0] ram [MEM_WORDS];

    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]       count_q, count_d;
    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    req_t                 cur_q, cur_d;
    logic                 resp_valid_q, resp_valid_d;
    logic                 resp_is_store_q, resp_is_store_d;
    logic [31:0]          resp_rdata_q, resp_rdata_d;
    logic [TAG_WIDTH-1:0] resp_tag_q, resp_tag_d;
    logic                 resp_error_q, resp_error_d;

    logic             push, pop, do_access, acc_err;
    logic [IDX_W-1:0] word_idx;
    logic [1:0]       off;
    logic [31:0]      rd_word, load_data, wdata_sh;
    logic [15:0]      lane;
    logic [3:0]       byte_en;

    assign req_ready = (count_q < (PTR_W+1)'(REQ_DEPTH));
    assign push      = req_valid && req_ready;

    // Access decode works on the entry popped into cur_q, which stays put until the next pop.
    always_comb begin
        word_idx = cur_q.addr[IDX_W+1:2];
        off      = cur_q.addr[1:0];
        acc_err  = ((cur_q.addr >> (IDX_W + 2)) != '0)
                || (cur_q.size == 2'd3)
                || (cur_q.size == 2'd1 && off[0])
                || (cur_q.size == 2'd2 && off != 2'd0);
        rd_word  = ram[word_idx];
        lane     = 16'(rd_word >> {off, 3'b000});
        wdata_sh = cur_q.wdata << {off, 3'b000};
        case (cur_q.size)
            2'd0: begin
                byte_en   = 4'b0001 << off;
                load_data = cur_q.is_unsigned ? {24'b0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
            end
            2'd1: begin
                byte_en   = 4'b0011 << off;
                load_data = cur_q.is_unsigned ? {16'b0, lane} : {{16{lane[15]}}, lane};
            end
            default: begin
                byte_en   = 4'b1111;
                load_data = rd_word;
            end
        endcase
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        cur_d           = cur_q;
        pop             = 1'b0;
        do_access       = 1'b0;
        resp_valid_d    = resp_valid_q;
        resp_is_store_d = resp_is_store_q;
        resp_rdata_d    = resp_rdata_q;
        resp_tag_d      = resp_tag_q;
        resp_error_d    = resp_error_q;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_WAIT;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    cur_d   = fifo_mem[rd_ptr_q];
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    do_access       = 1'b1;
                    state_d         = S_RESP;
                    resp_valid_d    = 1'b1;
                    resp_is_store_d = cur_q.is_store;
                    resp_tag_d      = cur_q.tag;
                    resp_error_d    = acc_err;
                    resp_rdata_d    = (cur_q.is_store || acc_err) ? 32'b0 : load_data;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                        cur_d   = fifo_mem[rd_ptr_q];
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            cur_q           <= '0;
            resp_valid_q    <= 1'b0;
            resp_is_store_q <= 1'b0;
            resp_rdata_q    <= '0;
            resp_tag_q      <= '0;
            resp_error_q    <= 1'b0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            cur_q           <= cur_d;
            resp_valid_q    <= resp_valid_d;
            resp_is_store_q <= resp_is_store_d;
            resp_rdata_q    <= resp_rdata_d;
            resp_tag_q      <= resp_tag_d;
            resp_error_q    <= resp_error_d;
        end
    end

    // Storage arrays carry no reset so they map onto RAM primitives.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= '{is_store: req_is_store, addr: req_addr, size: req_size,
                                    is_unsigned: req_unsigned, wdata: req_wdata, tag: req_tag};
        end
    end

    always_ff @(posedge clk) begin
        if (do_access && cur_q.is_store && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) ram[word_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
            end
        end
    end

    assign resp_valid    = resp_valid_q;
    assign resp_is_store = resp_is_store_q;
    assign resp_rdata    = resp_rdata_q;
    assign resp_tag      = resp_tag_q;
    assign resp_error    = resp_error_q;
endmodule
